aha_sif_wr_splitter: RTL and testbench

- Sits directly downstream of the AXI-to-SIF write converter in the Garnet integration path.
- Consumes 64-bit fire-and-forget SIF writes (address, byte strobe, write-enable, data) and buffers them in a small FIFO.
- Replays each write as one or two 32-bit writes on a valid/ready target port, which feeds the 32-bit CGRA/GLB configuration space.
- The SIF side has no backpressure, so the block flags dropped writes with a sticky overflow bit.

---
 rtl/aha_sif_pkg.sv | 24 ++
 rtl/aha_sif_wr_splitter_if.sv | 26 ++
 rtl/aha_sif_sync_fifo.sv | 52 +++++
 rtl/aha_sif_wr_splitter.sv | 131 +++++++++++++
 tb/tb_aha_sif_wr_splitter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aha_sif_pkg.sv
// Shared types and constants for the SIF 64-to-32 write splitter.
// Entry layout and output FSM encoding live here.
package aha_sif_pkg;

    localparam int SIF_DATA_W = 64;
    localparam int SIF_STRB_W = 8;
    localparam int TGT_DATA_W = 32;
    localparam int TGT_STRB_W = 4;

    typedef struct packed {
        logic [28:0]           addr;
        logic [SIF_STRB_W-1:0] strb;
        logic [SIF_DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

endpackage

// File: rtl/aha_sif_wr_splitter_if.sv
// SIF write input and 32-bit target request bundle.
// master = upstream/target environment, slave = splitter.
interface aha_sif_wr_splitter_if;
    import aha_sif_pkg::*;

    logic [31:0]           SIF_ADDR;
    logic [SIF_STRB_W-1:0] SIF_STRB;
    logic                  SIF_WE;
    logic [SIF_DATA_W-1:0] SIF_DATA;
    logic                  TGT_VALID;
    logic [31:0]           TGT_ADDR;
    logic [TGT_DATA_W-1:0] TGT_DATA;
    logic [TGT_STRB_W-1:0] TGT_STRB;
    logic                  TGT_READY;

    modport master (
        output SIF_ADDR, SIF_STRB, SIF_WE, SIF_DATA, TGT_READY,
        input  TGT_VALID, TGT_ADDR, TGT_DATA, TGT_STRB
    );

    modport slave (
        input  SIF_ADDR, SIF_STRB, SIF_WE, SIF_DATA, TGT_READY,
        output TGT_VALID, TGT_ADDR, TGT_DATA, TGT_STRB
    );

endinterface

// File: rtl/aha_sif_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers.
// Exposes the head and the entry behind it for gap-free replay.
module aha_sif_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [W-1:0]     dout_nxt,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  rd_nxt;
    logic [AW:0]  diff;

    assign rd_nxt   = rd_ptr + 1'b1;
    assign diff     = wr_ptr - rd_ptr;
    assign dout     = mem[rd_ptr[AW-1:0]];
    assign dout_nxt = mem[rd_nxt[AW-1:0]];
    assign full     = (diff == (AW+1)'(DEPTH));
    assign empty    = (diff == '0);
    assign level    = LVL_W'(diff);

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update; a push into a full FIFO relies on the caller popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nxt;
        end
    end

endmodule

// File: rtl/aha_sif_wr_splitter.sv
// Buffers 64-bit SIF writes and replays them as one or two
// 32-bit valid/ready requests; drops on full set a sticky flag.
module aha_sif_wr_splitter
    import aha_sif_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    aha_sif_wr_splitter_if.slave  bus,
    output logic [LVL_W-1:0]      FIFO_LEVEL,
    output logic                  OVERFLOW,
    input  logic                  OVERFLOW_CLR,
    output logic                  IDLE
);

    entry_t    in_ent;
    entry_t    head;
    entry_t    head_nxt;
    entry_t    load_ent;
    logic      full;
    logic      empty;
    logic      push_req;
    logic      push;
    logic      drop;
    logic      hs;
    logic      retire;
    logic      load;
    logic      load_hi;
    logic      to_empty;
    state_t    state;
    logic        tgt_valid;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_data;
    logic [3:0]  tgt_strb;

    assign in_ent   = '{addr: bus.SIF_ADDR[31:3],
                        strb: bus.SIF_STRB,
                        data: bus.SIF_DATA};
    assign push_req = bus.SIF_WE && (|bus.SIF_STRB);
    assign push     = push_req && (!full || retire);
    assign drop     = push_req && full && !retire;
    assign hs       = tgt_valid && bus.TGT_READY;

    aha_sif_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (ACLK),
        .rst      (ARESET),
        .push     (push),
        .din      (in_ent),
        .pop      (retire),
        .dout     (head),
        .dout_nxt (head_nxt),
        .full     (full),
        .empty    (empty),
        .level    (FIFO_LEVEL)
    );

    // Decide what the request register presents after this edge.
    always_comb begin
        load     = 1'b0;
        load_hi  = 1'b0;
        load_ent = head;
        to_empty = 1'b0;
        retire   = 1'b0;
        unique case (state)
            ST_EMPTY: load = !empty;
            ST_LO: begin
                if (hs) begin
                    if (|head.strb[7:4]) begin
                        load    = 1'b1;
                        load_hi = 1'b1;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            ST_HI: retire = hs;
            default: ;
        endcase
        if (retire) begin
            if (FIFO_LEVEL >= LVL_W'(2)) begin
                load     = 1'b1;
                load_ent = head_nxt;
            end else begin
                to_empty = 1'b1;
            end
        end
        if (load && !load_hi) load_hi = ~|load_ent.strb[3:0];
    end

    // Output FSM with registered request fields.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_EMPTY;
            tgt_valid <= 1'b0;
            tgt_addr  <= '0;
            tgt_data  <= '0;
            tgt_strb  <= '0;
        end else if (load) begin
            state     <= load_hi ? ST_HI : ST_LO;
            tgt_valid <= 1'b1;
            tgt_addr  <= {load_ent.addr, load_hi, 2'b00};
            tgt_data  <= load_hi ? load_ent.data[63:32]
                                 : load_ent.data[31:0];
            tgt_strb  <= load_hi ? load_ent.strb[7:4]
                                 : load_ent.strb[3:0];
        end else if (to_empty) begin
            state     <= ST_EMPTY;
            tgt_valid <= 1'b0;
        end
    end

    // Sticky drop flag; a drop beats a clear in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET)            OVERFLOW <= 1'b0;
        else if (drop)         OVERFLOW <= 1'b1;
        else if (OVERFLOW_CLR) OVERFLOW <= 1'b0;
    end

    assign bus.TGT_VALID = tgt_valid;
    assign bus.TGT_ADDR  = tgt_addr;
    assign bus.TGT_DATA  = tgt_data;
    assign bus.TGT_STRB  = tgt_strb;
    assign IDLE          = (FIFO_LEVEL == '0) && !tgt_valid;

endmodule

// File: tb/tb_aha_sif_wr_splitter.sv
// Directed bench for aha_sif_wr_splitter: table of single beats
// plus backpressure, overflow, full+retire and reset sequences.
module tb_aha_sif_wr_splitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr;
    logic       idle;
    int         checks   = 0;
    int         failures = 0;

    logic [31:0] ga [32];
    logic [31:0] gd [32];
    logic [3:0]  gs [32];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic        we;
        logic [63:0] data;
        int          n;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  s1;
    } vec_t;

    vec_t vt [6];

    aha_sif_wr_splitter_if bus ();

    aha_sif_wr_splitter #(.FIFO_DEPTH(4)) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .bus          (bus),
        .FIFO_LEVEL   (level),
        .OVERFLOW     (ovf),
        .OVERFLOW_CLR (ovf_clr),
        .IDLE         (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] a, input logic [7:0] s,
                        input logic [63:0] d);
        bus.SIF_WE   = 1'b1;
        bus.SIF_ADDR = a;
        bus.SIF_STRB = s;
        bus.SIF_DATA = d;
        step();
        bus.SIF_WE   = 1'b0;
    endtask

    task automatic drain(input int cyc, output int n);
        n = 0;
        bus.TGT_READY = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            if (bus.TGT_VALID) begin
                if (n < 32) begin
                    ga[n] = bus.TGT_ADDR;
                    gd[n] = bus.TGT_DATA;
                    gs[n] = bus.TGT_STRB;
                end
                n++;
            end
            step();
        end
    endtask

    initial begin
        int n;
        vt[0] = '{32'h1000_0010, 8'hFF, 1'b1, 64'h1122334455667788, 2,
                  32'h1000_0010, 32'h55667788, 4'hF,
                  32'h1000_0014, 32'h11223344, 4'hF};
        vt[1] = '{32'h2000_0008, 8'hF0, 1'b1, 64'hAABBCCDD_00000000, 1,
                  32'h2000_000C, 32'hAABBCCDD, 4'hF,
                  32'h0, 32'h0, 4'h0};
        vt[2] = '{32'h3000_0000, 8'h0C, 1'b1, 64'h00000000_12345678, 1,
                  32'h3000_0000, 32'h12345678, 4'hC,
                  32'h0, 32'h0, 4'h0};
        vt[3] = '{32'h3100_0000, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                  32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vt[4] = '{32'h4000_0007, 8'h81, 1'b1, 64'hDEADBEEF_CAFEF00D, 2,
                  32'h4000_0000, 32'hCAFEF00D, 4'h1,
                  32'h4000_0004, 32'hDEADBEEF, 4'h8};
        vt[5] = '{32'h4100_0000, 8'hFF, 1'b0, 64'h1, 0,
                  32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};

        rst = 1'b1;
        ovf_clr = 1'b0;
        bus.SIF_WE = 1'b0;
        bus.SIF_ADDR = '0;
        bus.SIF_STRB = '0;
        bus.SIF_DATA = '0;
        bus.TGT_READY = 1'b0;
        step();
        step();
        check("rst_valid", bus.TGT_VALID, 0);
        check("rst_addr", bus.TGT_ADDR, 0);
        check("rst_data", bus.TGT_DATA, 0);
        check("rst_strb", bus.TGT_STRB, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            bus.TGT_READY = 1'b1;
            bus.SIF_WE   = vt[v].we;
            bus.SIF_ADDR = vt[v].addr;
            bus.SIF_STRB = vt[v].strb;
            bus.SIF_DATA = vt[v].data;
            step();
            bus.SIF_WE = 1'b0;
            check($sformatf("v%0d_level", v), level, (vt[v].n > 0) ? 1 : 0);
            drain(8, n);
            check($sformatf("v%0d_count", v), n, vt[v].n);
            if (vt[v].n >= 1) begin
                check($sformatf("v%0d_a0", v), ga[0], vt[v].a0);
                check($sformatf("v%0d_d0", v), gd[0], vt[v].d0);
                check($sformatf("v%0d_s0", v), gs[0], vt[v].s0);
            end
            if (vt[v].n >= 2) begin
                check($sformatf("v%0d_a1", v), ga[1], vt[v].a1);
                check($sformatf("v%0d_d1", v), gd[1], vt[v].d1);
                check($sformatf("v%0d_s1", v), gs[1], vt[v].s1);
            end
            check($sformatf("v%0d_idle", v), idle, 1);
        end

        // Latency and backpressure hold on LO.
        bus.TGT_READY = 1'b0;
        beat(32'h5000_0000, 8'hFF, 64'h00000002_00000001);
        check("bp_lat_pre", bus.TGT_VALID, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.TGT_VALID, 1);
            check("bp_addr", bus.TGT_ADDR, 32'h5000_0000);
            check("bp_data", bus.TGT_DATA, 32'h1);
            check("bp_strb", bus.TGT_STRB, 4'hF);
            step();
        end
        drain(6, n);
        check("bp_count", n, 2);
        check("bp_a0", ga[0], 32'h5000_0000);
        check("bp_a1", ga[1], 32'h5000_0004);
        check("bp_d1", gd[1], 32'h2);
        check("bp_idle", idle, 1);

        // Overflow: six beats into a stalled depth-4 FIFO.
        bus.TGT_READY = 1'b0;
        for (int i = 0; i < 6; i++)
            beat(32'h6000_0000 + 32'(8 * i), 8'hFF,
                 {32'(2 * i + 1), 32'(2 * i)});
        check("ov_level", level, 4);
        check("ov_flag", ovf, 1);
        drain(20, n);
        check("ov_count", n, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ov_a%0d", k), ga[k], 32'h6000_0000 + 32'(4 * k));
            check($sformatf("ov_d%0d", k), gd[k], 32'(k));
        end
        check("ov_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ov_clr", ovf, 0);

        // Full FIFO: push coincides with HI retire of the head.
        bus.TGT_READY = 1'b0;
        for (int i = 0; i < 4; i++)
            beat(32'h7000_0000 + 32'(8 * i), 8'hFF,
                 {32'(2 * i + 32'h101), 32'(2 * i + 32'h100)});
        step();
        check("fr_level_full", level, 4);
        bus.TGT_READY = 1'b1;
        step();
        check("fr_hi_addr", bus.TGT_ADDR, 32'h7000_0004);
        beat(32'h7000_0020, 8'hFF, 64'h00000109_00000108);
        check("fr_ovf", ovf, 0);
        check("fr_level", level, 4);
        drain(20, n);
        check("fr_count", n, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fr_a%0d", k), ga[k], 32'h7000_0008 + 32'(4 * k));
            check($sformatf("fr_d%0d", k), gd[k], 32'h102 + 32'(k));
        end

        // Drop and clear together, then reset while in HI.
        bus.TGT_READY = 1'b0;
        for (int i = 0; i < 4; i++)
            beat(32'h8000_0000 + 32'(8 * i), 8'hFF, 64'(i + 32'h55));
        ovf_clr = 1'b1;
        beat(32'h8000_0020, 8'hFF, 64'h99);
        ovf_clr = 1'b0;
        check("sw_ovf", ovf, 1);
        check("sw_level", level, 4);
        bus.TGT_READY = 1'b1;
        step();
        bus.TGT_READY = 1'b0;
        check("rm_hi_addr", bus.TGT_ADDR, 32'h8000_0004);
        check("rm_hi_valid", bus.TGT_VALID, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_valid", bus.TGT_VALID, 0);
        check("rm_level", level, 0);
        check("rm_idle", idle, 1);
        check("rm_ovf", ovf, 0);
        drain(10, n);
        check("rm_stale", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
